// File: rtl/seg7_pkg.sv
// Shared constants, types and state encoding for the 7-segment display path.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned SEG_W      = 7;

    // Patterns are {a,b,c,d,e,f,g}, 1 = lit.
    localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_OVF = 7'b0011101;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic             dp;
    } digit_t;

endpackage

// File: rtl/seg7_refresh_timer.sv
// Digit-slot prescaler: flags the last cycle of a slot and whether the
// slot position reached on the next edge falls inside the blank interval.
module seg7_refresh_timer #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_slot_end_c,
    output logic o_in_blank_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign o_slot_end_c = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_cnt_next   = o_slot_end_c ? '0 : r_cnt + CNT_W'(1);
    // Looking one edge ahead lets the registered FSM land exactly on the count.
    assign o_in_blank_c = (32'(w_cnt_next) < BLANK_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit buffer and time-multiplexed common-anode scan with blank interval;
// every pin-facing output is registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [SEG_W-1:0]      wr_seg,
    input  logic                  wr_dp,
    input  logic                  blank_all,
    output logic [SEG_W-1:0]      seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_tick
);

    localparam logic [SEG_W-1:0]      SEG_MASK = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic                  w_slot_end;
    logic                  w_in_blank;
    scan_state_t           r_state;
    scan_state_t           w_state_next;
    digit_t                r_buf [NUM_DIGITS];
    logic [IDX_W-1:0]      r_scan_idx;
    logic                  r_frame_tick;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  w_lit;
    digit_t                w_digit;
    logic [NUM_DIGITS-1:0] w_an_on;
    logic [SEG_W-1:0]      w_seg_on;
    logic                  w_dp_on;

    seg7_refresh_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_slot_end_c (w_slot_end),
        .o_in_blank_c (w_in_blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCAN_BLANK: if (!w_in_blank) w_state_next = SCAN_ON;
            SCAN_ON:    if (w_in_blank)  w_state_next = SCAN_BLANK;
            default:    w_state_next = SCAN_BLANK;
        endcase
    end

    // Digit buffer and scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                r_buf[i] <= '0;
            end
            r_scan_idx   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (wr_en) begin
                r_buf[wr_addr] <= {wr_seg, wr_dp};
            end
            if (w_slot_end) begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
            r_frame_tick <= w_slot_end && (r_scan_idx == IDX_W'(NUM_DIGITS - 1));
        end
    end

    always_comb begin
        w_lit    = (r_state == SCAN_ON) && !blank_all;
        w_digit  = r_buf[r_scan_idx];
        w_an_on  = '0;
        w_seg_on = SEG_OFF;
        w_dp_on  = 1'b0;
        if (w_lit) begin
            w_an_on  = NUM_DIGITS'(1) << r_scan_idx;
            w_seg_on = w_digit.seg;
            w_dp_on  = w_digit.dp;
        end
    end

    // Polarity is applied as an XOR mask so reset lands on the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_MASK;
            r_dp  <= SEG_ACTIVE_LOW;
            r_an  <= AN_MASK;
        end else begin
            r_seg <= w_seg_on ^ SEG_MASK;
            r_dp  <= w_dp_on ^ SEG_ACTIVE_LOW;
            r_an  <= w_an_on ^ AN_MASK;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign scan_idx   = r_scan_idx;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream stage of the add/subtract/select/decode path.
- Stores the 7-segment patterns produced by the decoder, one per digit, in a 4-digit buffer.
- Time-multiplexes the buffer onto a common-anode 4-digit display: refresh prescaler, digit scan counter, and an anti-ghosting blank interval at the start of each digit slot.
- All outputs are registered; the block is the last logic before the board pins.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot. Must be at least 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off. Range 0 to CLK_DIV-1; 0 means no blank phase.
- SEG_ACTIVE_LOW, 1: 1 means seg_out and dp_out are driven inverted, so 0 lights a segment.
- AN_ACTIVE_LOW, 1: 1 means an_out is active-low, so 0 enables a digit.

Ports:
- clk, in, 1: single system clock. All state updates on its rising edge.
- rst_n, in, 1: reset. Asynchronous, active-low.
- wr_en, in, 1: write strobe for the digit buffer.
- wr_addr, in, 2: digit index to write. 0 is the rightmost digit.
- wr_seg, in, 7: pattern {a,b,c,d,e,f,g}, where 1 means the segment is lit (decoder encoding).
- wr_dp, in, 1: decimal point for the written digit, 1 means lit. Used as the overflow indicator.
- blank_all, in, 1: level input. Forces the display dark.
- seg_out, out, 7: segment drive, polarity set by SEG_ACTIVE_LOW.
- dp_out, out, 1: decimal point drive, polarity set by SEG_ACTIVE_LOW.
- an_out, out, 4: anode enables, one-hot when active, polarity set by AN_ACTIVE_LOW.
- scan_idx, out, 2: index of the digit currently in its slot.
- frame_tick, out, 1: one-cycle pulse at the end of digit 3's slot.

Behaviour:
- Reset (rst_n low, takes effect immediately without a clock edge):
  - Digit buffer cleared to 0 (all segments off, dp off).
  - Prescaler cleared to 0, scan_idx = 0, FSM in BLANK, frame_tick = 0.
  - an_out, seg_out and dp_out at their inactive level. With default parameters: an_out = 4'b1111, seg_out = 7'b1111111, dp_out = 1.
- Buffer write:
  - On a rising edge with wr_en = 1, the entry at wr_addr is set to {wr_seg, wr_dp}.
  - Writes are accepted every cycle; there is no back-pressure.
  - The last write wins.
- Prescaler (cnt):
  - Counts 0 to CLK_DIV-1 and wraps to 0.
  - When cnt = CLK_DIV-1, scan_idx advances on the same edge, wrapping 3 to 0.
- frame_tick: registered, high for exactly one cycle, in the cycle after the edge where scan_idx wraps 3 to 0.
- FSM states:
  - BLANK: while cnt < BLANK_CYCLES.
  - ON: otherwise.
  - Transitions BLANK to ON at cnt = BLANK_CYCLES; ON to BLANK at the slot wrap.
  - With BLANK_CYCLES = 0, the FSM stays in ON.
- Output latency:
  - Outputs in cycle n+1 reflect the FSM state, scan_idx and buffer contents at cycle n. Latency is one cycle.
  - A write to the displayed digit changes seg_out on the cycle after the write edge.
- Output values:
  - ON and blank_all = 0: an_out enables only digit scan_idx; seg_out and dp_out show that digit's entry.
  - BLANK, or blank_all = 1: an_out all inactive and seg_out inactive.
- blank_all does not stop the prescaler or scan_idx; scanning resumes in phase when it is released.
- Simultaneous write and slot advance: both take effect. The new digit shows its new contents once its slot reaches ON.
- No arithmetic on pattern data; wr_seg is stored and driven bit-exact.

Decomposition:
- Shared package seg7_pkg contains:
  - Pattern constants SEG_0 to SEG_F (e.g. SEG_0 = 7'b1111110, SEG_F = 7'b1000111).
  - SEG_OVF = 7'b0011101 and SEG_OFF = 7'b0000000.
  - Scan FSM state encoding SCAN_BLANK / SCAN_ON.
  - NUM_DIGITS = 4.
- One sub-module, seg7_refresh_timer: holds the prescaler and its compares, and outputs slot_end and in_blank.
- The top level holds the buffer, scan_idx, the FSM and the output registers.

Test Plan (CLK_DIV = 8, BLANK_CYCLES = 2, active-low defaults):
1. Hold rst_n = 0 with no clock edges -> an_out = 4'b1111, seg_out = 7'b1111111, dp_out = 1, frame_tick = 0 immediately.
2. Write addr0 = SEG_0 with dp = 0, release reset -> per slot: 2 cycles with an_out = 4'b1111, then 6 cycles with an_out = 4'b1110 and seg_out = 7'b0000001.
3. Write addr1 = SEG_1 with dp = 1, free-run 64 cycles -> slot 1 shows an_out = 4'b1101, seg_out = 7'b1001111, dp_out = 0; scan_idx follows 0,1,2,3,0; frame_tick pulses exactly twice, 32 cycles apart.
4. Write addr0 = SEG_OVF at mid-ON of slot 0 -> seg_out becomes 7'b1100010 on the next cycle, and an_out does not glitch.
5. Assert blank_all for 5 cycles during an ON phase -> an_out = 4'b1111 from the next cycle; after release, scan_idx and cnt match a run without blank_all.
6. Pulse rst_n low at cnt = 4 of slot 2 -> outputs go inactive asynchronously and the buffer is cleared; after release, scan restarts at scan_idx = 0, cnt = 0.
